// File: rtl/project_factorial_pkg.sv
// Shared definitions for the factorial unit: default data width and FSM states.
// Pure declarations, no logic.
// Imported by the top and the datapath.
package project_factorial_pkg;

  // default width of operand, result, accumulator and counter
  localparam int DEF_WIDTH = 8;

  // controller states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/project_factorial_dp.sv
// Factorial datapath: accumulator/counter registers, truncating multiplier,
// decrementer, end-of-count compare and the result register.
// One multiply-decrement step per cycle while step is high; no backpressure.
module project_factorial_dp
  import project_factorial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk0,
  input  logic             rst0,
  input  logic             load,
  input  logic             step,
  input  logic             latch,
  input  logic [WIDTH-1:0] valor,
  output logic             last,
  output logic [WIDTH-1:0] resultado
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] cnt_dec;

  // a same-width product keeps only the low bits, i.e. the result wraps mod 2^WIDTH
  assign prod    = acc * cnt;
  assign cnt_dec = cnt - WIDTH'(1);
  assign last    = (cnt <= WIDTH'(1));

  // accumulator/counter: seeded on an accepted start, then one step per CALC cycle
  always_ff @(posedge clk0 or negedge rst0) begin
    if (!rst0) begin
      acc <= WIDTH'(1);
      cnt <= '0;
    end else if (load) begin
      acc <= WIDTH'(1);
      cnt <= valor;
    end else if (step) begin
      acc <= prod;
      cnt <= cnt_dec;
    end
  end

  // result register: written only when the computation finishes, held otherwise
  always_ff @(posedge clk0 or negedge rst0) begin
    if (!rst0) begin
      resultado <= '0;
    end else if (latch) begin
      resultado <= acc;
    end
  end

endmodule

// File: rtl/project_factorial.sv
// Sequential factorial unit: valor! mod 2^WIDTH by iterative multiply-and-decrement.
// Latency: start sampled at edge k -> done/resultado valid after edge k+max(valor,1).
// start is a level request seen only in IDLE; DONE is held while start stays high.
module project_factorial
  import project_factorial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk0,
  input  logic             rst0,
  input  logic             start,
  input  logic [WIDTH-1:0] valor,
  output logic [WIDTH-1:0] resultado,
  output logic             done
);

  state_t state;
  state_t state_nxt;
  logic   load;
  logic   step;
  logic   latch;
  logic   last;

  // state register
  always_ff @(posedge clk0 or negedge rst0) begin
    if (!rst0) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: a new run needs start low in DONE before it can be requested again
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath controls and done flag, decoded from the registered state
  always_comb begin
    load  = 1'b0;
    step  = 1'b0;
    latch = 1'b0;
    done  = 1'b0;
    unique case (state)
      IDLE:    load = start;
      CALC: begin
        step  = !last;
        latch = last;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  project_factorial_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk0      (clk0),
    .rst0      (rst0),
    .load      (load),
    .step      (step),
    .latch     (latch),
    .valor     (valor),
    .last      (last),
    .resultado (resultado)
  );

endmodule

// File: tb/tb_project_factorial.sv
// Self-checking bench for project_factorial: directed cases plus randomized runs
// compared against a plain-arithmetic factorial/latency model.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_project_factorial;

  logic       clk0;
  logic       rst0;
  logic       start;
  logic [7:0] valor;
  logic [7:0] resultado;
  logic       done;

  int checks;
  int errors;

  project_factorial dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .start     (start),
    .valor     (valor),
    .resultado (resultado),
    .done      (done)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  // n! reduced mod 256 at every step (same value as full n! mod 256)
  function automatic int ref_fact(input int n);
    int r;
    r = 1;
    for (int i = 2; i <= n; i++) r = (r * i) % 256;
    return r;
  endfunction

  // edges from the accepting edge up to and including the one raising done
  function automatic int ref_edges(input int n);
    return ((n < 1) ? 1 : n) + 1;
  endfunction

  // one computation: pulse -> start dropped after acceptance; mid_valor >= 0 is
  // driven onto valor during CALC; hold_cycles extra DONE cycles with start high
  task automatic run(input string tag, input int n, input bit pulse,
                     input int mid_valor, input int hold_cycles);
    int edges;
    int exp_res;
    exp_res = ref_fact(n);
    valor = 8'(n);
    start = 1'b1;
    tick();
    edges = 1;
    if (pulse) start = 1'b0;
    if (mid_valor >= 0) valor = 8'(mid_valor);
    while (!done && edges < 300) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, ref_edges(n));
    check({tag, "_result"}, int'(resultado), exp_res);
    if (!pulse) begin
      for (int i = 0; i < hold_cycles; i++) begin
        tick();
        check({tag, "_hold_done"}, int'(done), 1);
        check({tag, "_hold_result"}, int'(resultado), exp_res);
      end
    end
    start = 1'b0;
    tick();
    check({tag, "_done_drop"}, int'(done), 0);
    check({tag, "_result_kept"}, int'(resultado), exp_res);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0   = 1'b0;
    start  = 1'b0;
    valor  = '0;

    // reset state and idle behaviour
    tick();
    tick();
    check("rst_done", int'(done), 0);
    check("rst_result", int'(resultado), 0);
    rst0 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("idle_done", int'(done), 0);
    check("idle_result", int'(resultado), 0);

    // start held: 3! with DONE held while start stays high
    run("n3_hold", 3, 1'b0, -1, 3);

    // single-cycle boundary cases
    run("n0", 0, 1'b1, -1, 0);
    run("n1", 1, 1'b1, -1, 0);

    // truncation
    run("n5", 5, 1'b0, -1, 0);
    run("n6", 6, 1'b0, -1, 0);
    run("n8", 8, 1'b0, -1, 0);

    // asynchronous reset in the middle of a computation
    valor = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst0 = 1'b0;
    #1;
    check("abort_done", int'(done), 0);
    check("abort_result", int'(resultado), 0);
    tick();
    rst0 = 1'b1;
    tick();
    check("post_abort_done", int'(done), 0);
    check("post_abort_result", int'(resultado), 0);
    run("n4", 4, 1'b0, -1, 0);

    // operand change during CALC is ignored
    run("n3_chg", 3, 1'b0, 7, 1);

    // randomized runs
    for (int k = 0; k < 25; k++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                      : int'($urandom_range(0, 12));
      run($sformatf("rnd%0d", k), n, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1,
          int'($urandom_range(0, 2)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
